fetch_cache: RTL and testbench
==============================

# fetch_cache

Direct-mapped, write-through instruction cache between the processor's fetch stage (s0) and `slowmem`. Hits return the instruction word in the request cycle. Misses run one read transaction on the `slowmem` strobe/mfc handshake and fill the line. Processor data stores pass through this block to memory, updating any matching cached line, so self-modified code stays coherent.

## Interface
- `INDEXBITS`, 3: line index width; `LINES = 1 << INDEXBITS` (8, matching CACHESIZE).
- `NOPWORD`, 16'hc000: word returned on `fetch_data` whenever `fetch_ready` is 0 (decodes as OPNOP).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `fetch_req`  in  1  fetch of `fetch_addr` requested this cycle.
- `fetch_addr`  in  16  word address (pc of current thread).
- `fetch_ready`  out  1  `fetch_data` valid this cycle.
- `fetch_data`  out  16  instruction word, else NOPWORD.
- `st_req`  in  1  processor store request.
- `st_addr`, `st_data`  in  16 each  store address/data.
- `st_ack`  out  1  store accepted this cycle (issued to memory).
- `busy`  out  1  miss in progress (state ≠ IDLE).
- `mem_addr`, `mem_wdata`  out  16 each  to slowmem.
- `mem_rnotw`  out  1  1 = read, 0 = write.
- `mem_strobe`  out  1  request to slowmem.
- `mem_mfc`  in  1  slowmem read-complete pulse.
- `mem_rdata`  in  16  slowmem read data.

## Operation
- Storage: per line `valid` (1b), `tag` (16−INDEXBITS = 13b), `data` (16b). `idx = addr[INDEXBITS-1:0]`, `tag = addr[15:INDEXBITS]`.
- Hit = `fetch_req` & state IDLE & `valid[idx]` & tag match & !`st_req`.
- On hit: `fetch_ready = 1` and `fetch_data = data[idx]`, both combinational.
- FSM states: IDLE, MISS_REQ, MISS_WAIT.
- IDLE → MISS_REQ: `fetch_req` & !hit & !`st_req`. Latch `miss_addr <= fetch_addr`.
- MISS_REQ: `mem_strobe = 1`, `mem_rnotw = 1`, `mem_addr = miss_addr`; `st_ack = 0`. Unconditionally → MISS_WAIT.
- MISS_WAIT: on `mem_mfc`, write `data[idx(miss_addr)] <= mem_rdata`, set valid and tag, → IDLE. Otherwise stay.
- Stores are accepted in IDLE or MISS_WAIT whenever `st_req` = 1.
  - `mem_strobe = 1`, `mem_rnotw = 0`, `mem_addr = st_addr`, `mem_wdata = st_data`, `st_ack = 1`, all combinational.
  - If the store's line is valid with matching tag, `data <= st_data`. Store misses do not allocate.
- Store during MISS_WAIT to `miss_addr`: slowmem satisfies the pending read with `st_data`. The fill therefore writes `st_data`; no special case is needed.
- Store and fill completing on the same edge to the same index: the fill wins.
- Store and fetch miss in the same IDLE cycle: the store wins, `fetch_ready = 0`, and the miss is detected the following cycle if the request is held.
- `mem_mfc` in IDLE or MISS_REQ is ignored.
- Default memory-side outputs: `mem_strobe = 0`, `mem_rnotw = 1`, `mem_addr = miss_addr`, `mem_wdata = st_data`.
- `fetch_req` = 0 never changes cache contents.

## Timing
- Reset values:
  - State IDLE, all `valid` = 0, `miss_addr` = 0.
  - Outputs: `fetch_ready` 0, `fetch_data` NOPWORD, `st_ack` 0, `busy` 0, `mem_strobe` 0, `mem_rnotw` 1, `mem_addr` 0.
- Hit latency: 0 cycles, same cycle as `fetch_req`.
- Miss timing with slowmem MEMDELAY = 4 and a miss detected in cycle T:
  - Strobe in T+1.
  - `mem_mfc` high in T+6.
  - Line valid from T+7; a held request hits in T+7.
  - Total miss penalty = MEMDELAY + 3 = 7 cycles.
- Store: one cycle, acked combinationally. A store in MISS_WAIT does not extend the miss unless it satisfies the pending read early.
- Reset asserted mid-miss: return to IDLE and invalidate all lines asynchronously. A late `mem_mfc` from the abandoned read is ignored.
- Back-to-back misses: no IDLE gap is required beyond the one cycle in which the fill lands.

## Test plan
- Cold fetch after reset, mem[0x0000] = 16'h1005, `fetch_req` held:
  - Strobe read in T+1, `mem_mfc` in T+6.
  - `fetch_ready` = 1 with `fetch_data` = 16'h1005 in T+7.
  - Refetching 0x0000 hits in 0 cycles.
- Conflict eviction: fetch 0x0003, then 0x000B (same index 3).
  - 0x000B misses and evicts 0x0003.
  - Refetching 0x0003 misses again (7 cycles).
- Write-update: with 0x0003 cached, store 16'h1234 to 0x0003.
  - `st_ack` = 1 with strobe, `mem_rnotw` = 0.
  - Next fetch of 0x0003 hits with 16'h1234, no memory read.
- Store during miss: miss on 0x8001, then store 16'hBEEF to 0x8001 in MISS_WAIT.
  - `mem_mfc` arrives early with 16'hBEEF.
  - Line filled with 16'hBEEF; fetch returns 16'hBEEF.
- Simultaneous events: `st_req` (0x0010) and a missing fetch (0x0020) in the same IDLE cycle.
  - Write strobe this cycle, `fetch_ready` = 0.
  - Miss detected next cycle; read strobe for 0x0020 one cycle later.
- Reset mid-miss: assert `reset` = 0 two cycles after the read strobe.
  - `busy` → 0 and `valid` cleared immediately.
  - Stray `mem_mfc` is ignored; a later fetch of the same address misses.

Source files
------------

// File: rtl/fetch_cache.sv
// Direct-mapped write-through instruction cache between fetch and slowmem.
// Hits answer in the request cycle; misses run one strobe/mfc read transaction.
module fetch_cache #(
    parameter int          INDEXBITS = 3,
    parameter logic [15:0] NOPWORD   = 16'hc000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ready,
    output logic [15:0] fetch_data,
    input  logic        st_req,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    output logic        st_ack,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rnotw,
    output logic        mem_strobe,
    input  logic        mem_mfc,
    input  logic [15:0] mem_rdata
);

    localparam int LINES = 1 << INDEXBITS;
    localparam int TAGW  = 16 - INDEXBITS;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT
    } state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TAGW-1:0]   tags  [LINES];
    logic [15:0]       words [LINES];
    logic [15:0]       miss_addr;

    logic [INDEXBITS-1:0] f_idx, s_idx, m_idx;
    logic [TAGW-1:0]      f_tag, s_tag, m_tag;
    logic                 hit, st_go, st_hit, fill;

    assign f_idx = fetch_addr[INDEXBITS-1:0];
    assign f_tag = fetch_addr[15:INDEXBITS];
    assign s_idx = st_addr[INDEXBITS-1:0];
    assign s_tag = st_addr[15:INDEXBITS];
    assign m_idx = miss_addr[INDEXBITS-1:0];
    assign m_tag = miss_addr[15:INDEXBITS];

    assign hit = fetch_req && (state == IDLE) && valid[f_idx]
              && (tags[f_idx] == f_tag) && !st_req;

    // The bus is owned by the read strobe only in MISS_REQ.
    assign st_go  = st_req && (state != MISS_REQ);
    assign st_hit = st_go && valid[s_idx] && (tags[s_idx] == s_tag);
    assign fill   = (state == MISS_WAIT) && mem_mfc;

    always_comb begin
        fetch_ready = hit;
        fetch_data  = hit ? words[f_idx] : NOPWORD;
        st_ack      = st_go;
        busy        = (state != IDLE);
        mem_strobe  = (state == MISS_REQ) || st_go;
        mem_rnotw   = !st_go;
        mem_addr    = st_go ? st_addr : miss_addr;
        mem_wdata   = st_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req && !hit && !st_req) begin
                        state     <= MISS_REQ;
                        miss_addr <= fetch_addr;
                    end
                end
                MISS_REQ: state <= MISS_WAIT;
                MISS_WAIT: begin
                    if (mem_mfc) begin
                        state        <= IDLE;
                        valid[m_idx] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fill is written last so it wins over a same-edge store to the line.
    always_ff @(posedge clk) begin
        if (st_hit) begin
            words[s_idx] <= st_data;
        end
        if (fill) begin
            words[m_idx] <= mem_rdata;
            tags[m_idx]  <= m_tag;
        end
    end

endmodule

// File: tb/tb_fetch_cache.sv
// Directed bench for fetch_cache: hits, misses, eviction, stores,
// store/miss collisions and reset during a miss.
module tb_fetch_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ready;
    logic [15:0] fetch_data;
    logic        st_req;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_ack;
    logic        busy;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rnotw;
    logic        mem_strobe;
    logic        mem_mfc;
    logic [15:0] mem_rdata;

    int total  = 0;
    int passed = 0;

    fetch_cache dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_data (fetch_data),
        .st_req     (st_req),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ack     (st_ack),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rnotw  (mem_rnotw),
        .mem_strobe (mem_strobe),
        .mem_mfc    (mem_mfc),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Full miss with slowmem delay 4: strobe T+1, mfc T+6, hit T+7.
    task automatic miss_fill(input logic [15:0] a, input logic [15:0] d);
        fetch_req  = 1'b1;
        fetch_addr = a;
        st_req     = 1'b0;
        #1;
        chk("miss_ready", fetch_ready, 16'd0);
        chk("miss_nop", fetch_data, 16'hc000);
        tick;
        chk("rd_strobe", mem_strobe, 16'd1);
        chk("rd_rnotw", mem_rnotw, 16'd1);
        chk("rd_addr", mem_addr, a);
        chk("rd_busy", busy, 16'd1);
        chk("rd_ack", st_ack, 16'd0);
        repeat (4) begin
            tick;
            chk("wait_strobe", mem_strobe, 16'd0);
            chk("wait_busy", busy, 16'd1);
        end
        tick;
        mem_mfc   = 1'b1;
        mem_rdata = d;
        #1;
        chk("mfc_ready", fetch_ready, 16'd0);
        tick;
        mem_mfc   = 1'b0;
        mem_rdata = 16'h0;
        #1;
        chk("fill_ready", fetch_ready, 16'd1);
        chk("fill_data", fetch_data, d);
        chk("fill_busy", busy, 16'd0);
    endtask

    initial begin
        reset      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 16'h0;
        st_req     = 1'b0;
        st_addr    = 16'h0;
        st_data    = 16'h0;
        mem_mfc    = 1'b0;
        mem_rdata  = 16'h0;
        #2;
        chk("rst_ready", fetch_ready, 16'd0);
        chk("rst_data", fetch_data, 16'hc000);
        chk("rst_ack", st_ack, 16'd0);
        chk("rst_busy", busy, 16'd0);
        chk("rst_strobe", mem_strobe, 16'd0);
        chk("rst_rnotw", mem_rnotw, 16'd1);
        chk("rst_addr", mem_addr, 16'h0);
        tick;
        reset = 1'b1;
        tick;

        // Cold fetch, then 0-cycle refetch.
        miss_fill(16'h0000, 16'h1005);
        tick;
        chk("refetch_ready", fetch_ready, 16'd1);
        chk("refetch_data", fetch_data, 16'h1005);
        chk("refetch_strobe", mem_strobe, 16'd0);

        // Conflict eviction on index 3.
        miss_fill(16'h0003, 16'h3333);
        miss_fill(16'h000b, 16'hbbbb);
        tick;
        chk("evict_hit_b", fetch_data, 16'hbbbb);
        miss_fill(16'h0003, 16'h3333);

        // Write-update of a cached line.
        tick;
        fetch_req = 1'b0;
        st_req    = 1'b1;
        st_addr   = 16'h0003;
        st_data   = 16'h1234;
        #1;
        chk("st_ack", st_ack, 16'd1);
        chk("st_strobe", mem_strobe, 16'd1);
        chk("st_rnotw", mem_rnotw, 16'd0);
        chk("st_addr", mem_addr, 16'h0003);
        chk("st_wdata", mem_wdata, 16'h1234);
        chk("st_ready", fetch_ready, 16'd0);
        tick;
        st_req     = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0003;
        #1;
        chk("upd_ready", fetch_ready, 16'd1);
        chk("upd_data", fetch_data, 16'h1234);
        chk("upd_strobe", mem_strobe, 16'd0);
        tick;
        chk("upd_busy", busy, 16'd0);

        // Store to the missing address satisfies the read early.
        fetch_addr = 16'h8001;
        #1;
        chk("sm_miss", fetch_ready, 16'd0);
        tick;
        chk("sm_rd_addr", mem_addr, 16'h8001);
        tick;
        st_req  = 1'b1;
        st_addr = 16'h8001;
        st_data = 16'hbeef;
        #1;
        chk("sm_ack", st_ack, 16'd1);
        chk("sm_rnotw", mem_rnotw, 16'd0);
        chk("sm_addr", mem_addr, 16'h8001);
        tick;
        st_req    = 1'b0;
        mem_mfc   = 1'b1;
        mem_rdata = 16'hbeef;
        #1;
        chk("sm_busy", busy, 16'd1);
        tick;
        mem_mfc = 1'b0;
        #1;
        chk("sm_ready", fetch_ready, 16'd1);
        chk("sm_data", fetch_data, 16'hbeef);

        // Store and missing fetch in the same IDLE cycle.
        tick;
        fetch_addr = 16'h0020;
        st_req     = 1'b1;
        st_addr    = 16'h0010;
        st_data    = 16'h5555;
        #1;
        chk("co_strobe", mem_strobe, 16'd1);
        chk("co_rnotw", mem_rnotw, 16'd0);
        chk("co_addr", mem_addr, 16'h0010);
        chk("co_ready", fetch_ready, 16'd0);
        chk("co_ack", st_ack, 16'd1);
        tick;
        st_req = 1'b0;
        #1;
        chk("co_detect_strobe", mem_strobe, 16'd0);
        chk("co_detect_busy", busy, 16'd0);
        tick;
        chk("co_rd_strobe", mem_strobe, 16'd1);
        chk("co_rd_rnotw", mem_rnotw, 16'd1);
        chk("co_rd_addr", mem_addr, 16'h0020);

        // Reset two cycles after the read strobe.
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("rm_busy", busy, 16'd0);
        chk("rm_strobe", mem_strobe, 16'd0);
        chk("rm_addr", mem_addr, 16'h0);
        tick;
        reset     = 1'b1;
        fetch_req = 1'b0;
        mem_mfc   = 1'b1;
        mem_rdata = 16'h9999;
        tick;
        mem_mfc = 1'b0;
        #1;
        chk("rm_stray_busy", busy, 16'd0);
        fetch_req  = 1'b1;
        fetch_addr = 16'h0000;
        #1;
        chk("rm_inval", fetch_ready, 16'd0);
        chk("rm_inval_data", fetch_data, 16'hc000);
        miss_fill(16'h0020, 16'h2020);

        fetch_req = 1'b0;
        tick;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
